// File: rtl/sponge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sponge_pkg
// Brief    : Shared types, default widths and byte-mask helper for the
//            sponge squeeze engine.
// Revision : 1.0 - initial release
// ============================================================================
package sponge_pkg;

  // Squeeze engine control states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EMIT      = 3'd1,
    S_PERM_REQ  = 3'd2,
    S_PERM_WAIT = 3'd3,
    S_DONE      = 3'd4
  } squeeze_state_e;

  // Default width set
  localparam int DEF_STATE_W = 320;
  localparam int DEF_RATE_W  = 64;
  localparam int DEF_OUT_W   = 32;

  // Widest beat the mask helper can describe
  localparam int MASK_W = 512;

  // Keep-mask for n valid bytes of an out_w-bit beat, first byte in the MSBs.
  // Callers truncate the result to their own beat width.
  function automatic logic [MASK_W-1:0] byte_mask(input int unsigned n,
                                                  input int unsigned out_w);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if ((i < out_w) && ((i + 8 * n) >= out_w)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sponge_squeezer.sv
`default_nettype none
// ============================================================================
// Module   : sponge_squeezer
// Brief    : Squeeze-phase engine. Streams the requested number of bytes from
//            the rate portion of the held state, requesting permutations from
//            an external core whenever the rate runs out.
// Revision : 1.0 - initial release
// ============================================================================
module sponge_squeezer
  import sponge_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int RATE_W  = DEF_RATE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int LEN_W   = 20,
  parameter int CNT_W   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [STATE_W-1:0]         state_in,
  input  logic [LEN_W-1:0]           out_len,
  output logic                       perm_start,
  output logic [STATE_W-1:0]         perm_state_out,
  input  logic                       perm_done,
  input  logic [STATE_W-1:0]         perm_state_in,
  output logic [OUT_W-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(OUT_W/8):0]   dout_bytes,
  output logic                       dout_last,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           perm_count
);

  localparam int BYTES = OUT_W / 8;
  localparam int WORDS = RATE_W / OUT_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SEL_W = $clog2(STATE_W);
  localparam int BW    = $clog2(BYTES) + 1;

  squeeze_state_e     state_q, state_d;
  logic [STATE_W-1:0] held_state, held_d;
  logic [LEN_W-1:0]   remaining, remaining_d;
  logic [IDX_W-1:0]   beat_idx, beat_idx_d;
  logic [CNT_W-1:0]   perm_count_d;

  logic [SEL_W-1:0]   word_lsb;
  logic [OUT_W-1:0]   rate_word;
  logic [OUT_W-1:0]   keep;
  logic               partial;
  logic [LEN_W-1:0]   take;

  assign perm_state_out = held_state;

  // Select the current rate word and work out how many bytes this beat carries
  always_comb begin
    word_lsb  = SEL_W'(STATE_W - OUT_W - int'(beat_idx) * OUT_W);
    rate_word = held_state[word_lsb +: OUT_W];
    partial   = (remaining < LEN_W'(BYTES));
    take      = partial ? remaining : LEN_W'(BYTES);
    keep      = OUT_W'(byte_mask(32'(remaining), OUT_W));
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    held_d       = held_state;
    remaining_d  = remaining;
    beat_idx_d   = beat_idx;
    perm_count_d = perm_count;
    perm_start   = 1'b0;
    dout_valid   = 1'b0;
    dout         = '0;
    dout_bytes   = '0;
    dout_last    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          held_d       = state_in;
          remaining_d  = out_len;
          beat_idx_d   = '0;
          perm_count_d = '0;
          state_d      = (out_len == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        dout_valid = 1'b1;
        dout       = partial ? (rate_word & keep) : rate_word;
        dout_bytes = partial ? BW'(remaining) : BW'(BYTES);
        dout_last  = (remaining <= LEN_W'(BYTES));
        if (dout_ready) begin
          remaining_d = remaining - take;
          if (remaining == take) begin
            state_d = S_DONE;
          end else if (beat_idx == IDX_W'(WORDS - 1)) begin
            state_d = S_PERM_REQ;
          end else begin
            beat_idx_d = beat_idx + IDX_W'(1);
          end
        end
      end
      S_PERM_REQ: begin
        perm_start = 1'b1;
        if (perm_count != '1) perm_count_d = perm_count + CNT_W'(1);
        state_d = S_PERM_WAIT;
      end
      S_PERM_WAIT: begin
        if (perm_done) begin
          held_d     = perm_state_in;
          beat_idx_d = '0;
          state_d    = S_EMIT;
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      held_state <= '0;
      remaining  <= '0;
      beat_idx   <= '0;
      perm_count <= '0;
    end else begin
      state_q    <= state_d;
      held_state <= held_d;
      remaining  <= remaining_d;
      beat_idx   <= beat_idx_d;
      perm_count <= perm_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sponge_squeezer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sponge_squeezer
// Brief    : Directed table-driven bench for sponge_squeezer with a simple
//            state+1 permutation model and a reset-in-PERM_WAIT sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sponge_squeezer;

  localparam int STATE_W = 320;
  localparam int LEN_W   = 20;
  localparam int CNT_W   = 10;
  localparam logic [63:0] RATE_A = 64'h79657370_0803c003;
  localparam logic [63:0] RATE_B = 64'hA1B2C3D4_E5F60718;

  logic               clk;
  logic               reset;
  logic               start;
  logic [STATE_W-1:0] state_in;
  logic [LEN_W-1:0]   out_len;
  logic               perm_start;
  logic [STATE_W-1:0] perm_state_out;
  logic               perm_done;
  logic [STATE_W-1:0] perm_state_in;
  logic [31:0]        dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [2:0]         dout_bytes;
  logic               dout_last;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   perm_count;

  int total = 0;
  int bad   = 0;

  sponge_squeezer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .state_in       (state_in),
    .out_len        (out_len),
    .perm_start     (perm_start),
    .perm_state_out (perm_state_out),
    .perm_done      (perm_done),
    .perm_state_in  (perm_state_in),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .dout_bytes     (dout_bytes),
    .dout_last      (dout_last),
    .busy           (busy),
    .done           (done),
    .perm_count     (perm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       rate;
    logic              cap_ones;
    int                len;
    logic              rnd;
    logic              glitch;
    int                perms;
    int                done_cyc;
    int                nbeats;
    logic [7:0][31:0]  beat;
    logic [7:0][2:0]   nb;
  } vec_t;

  vec_t vecs[10];
  vec_t cur;
  int   nvec = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic begin_vec(input logic [63:0] rate, input logic cap_ones, input int len,
                           input logic rnd, input logic glitch, input int perms,
                           input int done_cyc);
    cur.rate = rate; cur.cap_ones = cap_ones; cur.len = len; cur.rnd = rnd;
    cur.glitch = glitch; cur.perms = perms; cur.done_cyc = done_cyc;
    cur.nbeats = 0; cur.beat = '0; cur.nb = '0;
  endtask

  task automatic add_beat(input logic [31:0] w, input logic [2:0] n);
    cur.beat[cur.nbeats] = w;
    cur.nb[cur.nbeats]   = n;
    cur.nbeats++;
  endtask

  task automatic end_vec();
    vecs[nvec] = cur;
    nvec++;
  endtask

  // Issue one request and follow it to its done pulse
  task automatic run_vec(input vec_t v);
    int beats = 0, pulses = 0, pend = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    bit fin = 0;
    state_in   = {v.rate, v.cap_ones ? {256{1'b1}} : 256'd0};
    out_len    = LEN_W'(v.len);
    start      = 1'b1;
    dout_ready = 1'b0;
    perm_done  = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      start = (v.glitch && cyc == 2);
      if (v.glitch && cyc == 2) begin
        state_in = ~state_in;
        out_len  = 20'd3;
      end
      perm_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          perm_done     = 1'b1;
          perm_state_in = perm_state_out + 1'b1;
        end
      end
      dout_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_valid", 64'(dout_valid), 64'd1);
        chk("stall_dout", 64'(dout), 64'(held));
      end
      stalled = dout_valid && !dout_ready;
      held    = dout;
      if (dout_valid && dout_ready) begin
        if (beats < v.nbeats) begin
          chk("beat_dout", 64'(dout), 64'(v.beat[beats]));
          chk("beat_bytes", 64'(dout_bytes), 64'(v.nb[beats]));
          chk("beat_last", 64'(dout_last), 64'(beats == v.nbeats - 1));
        end else begin
          chk("extra_beat", 64'(beats + 1), 64'(v.nbeats));
        end
        beats++;
      end
      if (perm_start) begin
        pulses++;
        pend = 3;
      end
      if (done) begin
        fin = 1;
        chk("nbeats", 64'(beats), 64'(v.nbeats));
        chk("perm_pulses", 64'(pulses), 64'(v.perms));
        chk("perm_count", 64'(perm_count), 64'(v.perms));
        chk("busy_at_done", 64'(busy), 64'd0);
        if (v.done_cyc >= 0) chk("done_cycle", 64'(cyc), 64'(v.done_cyc));
      end
    end
    if (!fin) chk("timeout_done", 64'd0, 64'd1);
    start = 1'b0;
    perm_done = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; state_in = '0; out_len = '0;
    perm_done = 1'b0; perm_state_in = '0; dout_ready = 1'b0;

    // Expected beat tables
    begin_vec(RATE_A, 1'b0, 8, 1'b0, 1'b0, 0, 3);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c003, 3'd4); end_vec();
    begin_vec(RATE_A, 1'b0, 5, 1'b0, 1'b0, 0, 3);
    add_beat(32'h79657370, 3'd4); add_beat(32'h08000000, 3'd1); end_vec();
    begin_vec(RATE_A, 1'b1, 20, 1'b0, 1'b1, 2, 14);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c003, 3'd4);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c004, 3'd4);
    add_beat(32'h79657370, 3'd4); end_vec();
    begin_vec(RATE_A, 1'b1, 20, 1'b1, 1'b0, 2, -1);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c003, 3'd4);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c004, 3'd4);
    add_beat(32'h79657370, 3'd4); end_vec();
    begin_vec(RATE_A, 1'b1, 19, 1'b0, 1'b0, 2, 14);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c003, 3'd4);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c004, 3'd4);
    add_beat(32'h79657300, 3'd3); end_vec();
    begin_vec(RATE_A, 1'b0, 1, 1'b0, 1'b0, 0, 2);
    add_beat(32'h79000000, 3'd1); end_vec();
    begin_vec(RATE_A, 1'b0, 0, 1'b0, 1'b0, 0, 1);
    end_vec();
    begin_vec(RATE_A, 1'b1, 12, 1'b0, 1'b0, 1, 8);
    add_beat(32'h79657370, 3'd4); add_beat(32'h0803c003, 3'd4);
    add_beat(32'h79657370, 3'd4); end_vec();
    begin_vec(RATE_B, 1'b0, 7, 1'b0, 1'b0, 0, 3);
    add_beat(32'ha1b2c3d4, 3'd4); add_beat(32'he5f60700, 3'd3); end_vec();

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_perm_start", 64'(perm_start), 64'd0);
    chk("rst_perm_count", 64'(perm_count), 64'd0);
    chk("rst_state_out", 64'(|perm_state_out), 64'd0);
    chk("rst_dout", 64'({dout, dout_bytes, dout_last}), 64'd0);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // Reset while waiting on the permutation, then a stray perm_done
    begin
      bit seen = 0;
      state_in   = {RATE_A, {256{1'b1}}};
      out_len    = 20'd20;
      start      = 1'b1;
      dout_ready = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (perm_start) seen = 1;
      end
      if (!seen) chk("timeout_perm_start", 64'd0, 64'd1);
      @(negedge clk);
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_valid", 64'(dout_valid), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_valid", 64'(dout_valid), 64'd0);
      chk("mid_rst_perm_start", 64'(perm_start), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_perm_count", 64'(perm_count), 64'd0);
      chk("mid_rst_state_out", 64'(|perm_state_out), 64'd0);
      perm_done     = 1'b1;
      perm_state_in = {RATE_B, 256'd5};
      @(negedge clk);
      perm_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
        chk("stray_valid", 64'(dout_valid), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        @(negedge clk);
      end
    end

    run_vec(vecs[0]);
    run_vec(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
